morse_key_controller: RTL and testbench

Single-key front end for the Morse entry path. It samples one straight-key input, measures press and release durations in prescaled ticks, and classifies each press as dot or dash. It drives one-cycle dot, dash and send pulses into the symbol accumulator (GetCode), so a user can enter codes without separate dot, dash and send buttons. Sits between the board key input and GetCode; the accumulator's own 5-bit code and reset behaviour are unchanged.

---
 rtl/morse_key_controller.sv | 203 ++++++++++++++++++++
 tb/tb_morse_key_controller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_controller.sv
// -----------------------------------------------------------------------------
// morse_key_controller
//
// Single straight-key front end for the Morse entry path. The raw key level is
// synchronised and edge-detected. Press and release durations are measured in
// prescaled ticks. Each press is classified as a dot or a dash. One-cycle dot,
// dash and send pulses are issued to the downstream symbol accumulator.
//
// Parameters
//   TICK_DIV    clk cycles per timing tick (>= 2)
//   DASH_TICKS  press length in ticks at or above which a press is a dash
//   GAP_TICKS   idle ticks after the last symbol that trigger an automatic send
//   MAX_SYMBOLS symbols per character; reaching it forces an immediate send
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   key        in   raw key level (1 = pressed), asynchronous to clk
//   enable     in   0 forces IDLE, clears counters, suppresses all pulses
//   dot        out  one-cycle dot pulse
//   dash       out  one-cycle dash pulse
//   send       out  one-cycle send (commit character) pulse
//   sym_count  out  symbols emitted since the last send
//   state      out  FSM state: 0 IDLE, 1 PRESS, 2 GAP, 3 SEND
// -----------------------------------------------------------------------------
module morse_key_controller #(
  parameter int TICK_DIV    = 100000,
  parameter int DASH_TICKS  = 3,
  parameter int GAP_TICKS   = 7,
  parameter int MAX_SYMBOLS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic       enable,
  output logic       dot,
  output logic       dash,
  output logic       send,
  output logic [2:0] sym_count,
  output logic [1:0] state
);

  localparam int CNT_MAX = (DASH_TICKS > GAP_TICKS) ? DASH_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PRE_W   = $clog2(TICK_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_TICKS);
  localparam logic [2:0]       SYM_MAX  = 3'(MAX_SYMBOLS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  // Input synchroniser and edge-detect history
  logic sync1_q;
  logic key_s_q;
  logic key_d_q;

  // FSM, timing and output registers
  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sym_q, sym_d;
  logic             dot_q, dot_d;
  logic             dash_q, dash_d;
  logic             send_q, send_d;

  logic             rise;
  logic             fall;
  logic             tick;
  logic [PRE_W-1:0] pre_adv;
  logic [CNT_W-1:0] cnt_adv;
  logic [2:0]       sym_inc;

  // The synchroniser keeps running while disabled so that a key held across
  // an enable transition never appears as a fresh rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      key_s_q <= 1'b0;
      key_d_q <= 1'b0;
    end else begin
      sync1_q <= key;
      key_s_q <= sync1_q;
      key_d_q <= key_s_q;
    end
  end

  assign rise = key_s_q & ~key_d_q;
  assign fall = ~key_s_q & key_d_q;
  assign tick = (pre_q == PRE_LAST);

  // Free-running advance values; overridden with zero on any state entry.
  assign pre_adv = tick ? '0 : pre_q + 1'b1;
  assign cnt_adv = (tick && (cnt_q != CNT_SAT)) ? cnt_q + 1'b1 : cnt_q;
  assign sym_inc = sym_q + 3'd1;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_adv;
    cnt_d   = cnt_adv;
    sym_d   = sym_q;
    dot_d   = 1'b0;
    dash_d  = 1'b0;
    send_d  = 1'b0;

    if (!enable) begin
      // Partially entered character is dropped without a send.
      state_d = S_IDLE;
      pre_d   = '0;
      cnt_d   = '0;
      sym_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pre_d = '0;
          cnt_d = '0;
          sym_d = '0;
          if (rise) begin
            state_d = S_PRESS;
          end
        end

        S_PRESS: begin
          if (fall) begin
            // Judged on the count before any coincident tick increments it.
            if (cnt_q >= DASH_C) begin
              dash_d = 1'b1;
            end else begin
              dot_d = 1'b1;
            end
            sym_d   = sym_inc;
            state_d = (sym_inc == SYM_MAX) ? S_SEND : S_GAP;
            pre_d   = '0;
            cnt_d   = '0;
          end
        end

        S_GAP: begin
          if (rise) begin
            state_d = S_PRESS;
            pre_d   = '0;
            cnt_d   = '0;
          end else if (cnt_adv >= GAP_C) begin
            state_d = S_SEND;
            pre_d   = '0;
            cnt_d   = '0;
          end
        end

        S_SEND: begin
          send_d = 1'b1;
          sym_d  = '0;
          pre_d  = '0;
          cnt_d  = '0;
          // A key already down here counts as the first press of the next
          // character; its edge may have been seen while in SEND.
          state_d = key_s_q ? S_PRESS : S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
          pre_d   = '0;
          cnt_d   = '0;
          sym_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      sym_q   <= '0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      send_q  <= send_d;
    end
  end

  assign dot       = dot_q;
  assign dash      = dash_q;
  assign send      = send_q;
  assign sym_count = sym_q;
  assign state     = state_q;

endmodule

// File: tb/tb_morse_key_controller.sv
module tb_morse_key_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic       enable;
  logic       dot;
  logic       dash;
  logic       send;
  logic [2:0] sym_count;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_dot, n_dash, n_send;
  int last_dot, last_dash, last_send;
  int overlap = 0;
  int consec  = 0;
  logic pd = 1'b0, pa = 1'b0, ps = 1'b0;
  int seq[$];

  morse_key_controller #(
    .TICK_DIV   (4),
    .DASH_TICKS (3),
    .GAP_TICKS  (5),
    .MAX_SYMBOLS(5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key      (key),
    .enable   (enable),
    .dot      (dot),
    .dash     (dash),
    .send     (send),
    .sym_count(sym_count),
    .state    (state)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge and log any output pulses seen there.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (dot)  begin n_dot++;  last_dot  = cyc; seq.push_back(1); end
    if (dash) begin n_dash++; last_dash = cyc; seq.push_back(2); end
    if (send) begin n_send++; last_send = cyc; seq.push_back(3); end
    if ((dot & dash) | (dot & send) | (dash & send)) overlap++;
    if ((dot & pd) | (dash & pa) | (send & ps)) consec++;
    pd = dot; pa = dash; ps = send;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    n_dot = 0; n_dash = 0; n_send = 0;
    last_dot = -1; last_dash = -1; last_send = -1;
    seq.delete();
  endtask

  task automatic press(input int n);
    key = 1'b1;
    steps(n);
    key = 1'b0;
  endtask

  task automatic wait_send(input int bound, output bit ok);
    int start;
    start = n_send;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (n_send != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key = 1'b0; enable = 1'b1;
    clear_log();
    steps(3);
    total++;
    if ({dot, dash, send, sym_count, state} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 00000000", {dot, dash, send, sym_count, state});
    end
    reset = 1'b0;
    steps(3);
    total++;
    if ({dot, dash, send, sym_count, state} !== 8'h00) begin
      bad++;
      $display("FAIL after_reset_idle: got %b want 00000000", {dot, dash, send, sym_count, state});
    end
  endtask

  task automatic test_single_dot();
    int c0;
    int d;
    bit ok;
    clear_log();
    press(6);
    c0 = cyc;
    steps(3);
    total++;
    if (last_dot != c0 + 3) begin
      bad++; $display("FAIL dot_latency: got cycle %0d want %0d", last_dot, c0 + 3);
    end
    total++;
    if (sym_count !== 3'd1) begin
      bad++; $display("FAIL dot_symcount: got %0d want 1", sym_count);
    end
    total++;
    if (state !== 2'd2) begin
      bad++; $display("FAIL dot_state_gap: got %0d want 2", state);
    end
    wait_send(40, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL gap_send_seen: got none want one send");
    end
    d = last_send - last_dot;
    total++;
    if (d < 20 || d > 22) begin
      bad++; $display("FAIL gap_send_delay: got %0d cycles want 20..22", d);
    end
    total++;
    if ({sym_count, state} !== 5'b000_00) begin
      bad++; $display("FAIL after_send_idle: got sym=%0d state=%0d want 0 0", sym_count, state);
    end
    total++;
    if (n_dot != 1 || n_dash != 0 || n_send != 1) begin
      bad++; $display("FAIL dot_counts: got dot=%0d dash=%0d send=%0d want 1 0 1", n_dot, n_dash, n_send);
    end
  endtask

  task automatic test_dash_then_dot();
    int c0;
    int c1;
    bit ok;
    clear_log();
    press(16);
    c0 = cyc;
    steps(3);
    total++;
    if (last_dash != c0 + 3 || n_dot != 0) begin
      bad++; $display("FAIL dash_pulse: got dash@%0d dots=%0d want dash@%0d dots=0", last_dash, n_dot, c0 + 3);
    end
    steps(5);
    press(8);
    c1 = cyc;
    steps(3);
    total++;
    if (last_dot != c1 + 3 || n_dash != 1) begin
      bad++; $display("FAIL short_dot: got dot@%0d dashes=%0d want dot@%0d dashes=1", last_dot, n_dash, c1 + 3);
    end
    total++;
    if (sym_count !== 3'd2) begin
      bad++; $display("FAIL dash_dot_symcount: got %0d want 2", sym_count);
    end
    wait_send(40, ok);
    total++;
    if (!ok || sym_count !== 3'd0) begin
      bad++; $display("FAIL dash_dot_send: got ok=%0d sym=%0d want 1 0", ok, sym_count);
    end
  endtask

  task automatic test_sequence();
    int code;
    bit ok;
    clear_log();
    press(6);
    steps(8);
    press(16);
    steps(8);
    press(6);
    steps(3);
    code = (seq.size() == 3) ? seq[0] * 100 + seq[1] * 10 + seq[2] : -1;
    total++;
    if (code != 121) begin
      bad++; $display("FAIL seq_order: got %0d want 121", code);
    end
    total++;
    if (n_send != 0) begin
      bad++; $display("FAIL seq_early_send: got %0d sends want 0", n_send);
    end
    wait_send(40, ok);
    steps(30);
    code = (seq.size() == 4) ? seq[0] * 1000 + seq[1] * 100 + seq[2] * 10 + seq[3] : -1;
    total++;
    if (!ok || code != 1213 || n_send != 1) begin
      bad++; $display("FAIL seq_final_send: got code=%0d sends=%0d want 1213 1", code, n_send);
    end
  endtask

  task automatic test_max_symbols();
    int r5;
    int c6;
    bit ok;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      press(6);
      steps(4);
    end
    press(6);
    r5 = cyc;
    step();
    key = 1'b1;
    steps(2);
    total++;
    if (n_dot != 5 || sym_count !== 3'd5 || state !== 2'd3) begin
      bad++; $display("FAIL fifth_dot: got dots=%0d sym=%0d state=%0d want 5 5 3", n_dot, sym_count, state);
    end
    steps(1);
    total++;
    if (last_send != r5 + 4 || n_send != 1) begin
      bad++; $display("FAIL forced_send: got send@%0d n=%0d want send@%0d n=1", last_send, n_send, r5 + 4);
    end
    total++;
    if (sym_count !== 3'd0 || state !== 2'd1) begin
      bad++; $display("FAIL send_to_press: got sym=%0d state=%0d want 0 1", sym_count, state);
    end
    steps(3);
    key = 1'b0;
    c6 = cyc;
    steps(3);
    total++;
    if (last_dot != c6 + 3 || n_dot != 6 || sym_count !== 3'd1) begin
      bad++; $display("FAIL sixth_dot: got dot@%0d dots=%0d sym=%0d want dot@%0d 6 1", last_dot, n_dot, sym_count, c6 + 3);
    end
    wait_send(40, ok);
    total++;
    if (!ok || n_send != 2) begin
      bad++; $display("FAIL max_cleanup_send: got ok=%0d sends=%0d want 1 2", ok, n_send);
    end
  endtask

  task automatic test_enable();
    clear_log();
    key = 1'b1;
    steps(10);
    total++;
    if (state !== 2'd1) begin
      bad++; $display("FAIL en_press_state: got %0d want 1", state);
    end
    enable = 1'b0;
    steps(5);
    total++;
    if (state !== 2'd0 || sym_count !== 3'd0) begin
      bad++; $display("FAIL en_forced_idle: got state=%0d sym=%0d want 0 0", state, sym_count);
    end
    enable = 1'b1;
    steps(5);
    total++;
    if (state !== 2'd0) begin
      bad++; $display("FAIL en_no_false_rise: got state=%0d want 0", state);
    end
    key = 1'b0;
    steps(30);
    total++;
    if (n_dot + n_dash + n_send != 0 || state !== 2'd0) begin
      bad++; $display("FAIL en_no_pulses: got pulses=%0d state=%0d want 0 0", n_dot + n_dash + n_send, state);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    press(6);
    steps(4);
    press(6);
    steps(3);
    total++;
    if (dot !== 1'b1 || sym_count !== 3'd2 || state !== 2'd2) begin
      bad++; $display("FAIL pre_reset_gap: got dot=%0d sym=%0d state=%0d want 1 2 2", dot, sym_count, state);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({dot, dash, send, sym_count, state} !== 8'h00) begin
      bad++; $display("FAIL async_reset_clear: got %b want 00000000", {dot, dash, send, sym_count, state});
    end
    steps(3);
    reset = 1'b0;
    steps(40);
    total++;
    if (n_send != 0 || state !== 2'd0) begin
      bad++; $display("FAIL no_send_after_reset: got sends=%0d state=%0d want 0 0", n_send, state);
    end
  endtask

  task automatic test_pulse_shape();
    total++;
    if (overlap != 0) begin
      bad++; $display("FAIL pulse_overlap: got %0d cycles want 0", overlap);
    end
    total++;
    if (consec != 0) begin
      bad++; $display("FAIL pulse_width: got %0d repeats want 0", consec);
    end
  endtask

  initial begin
    test_reset();
    test_single_dot();
    test_dash_then_dot();
    test_sequence();
    test_max_symbols();
    test_enable();
    test_reset_mid();
    test_pulse_shape();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
